// File: rtl/nib_bus_pkg.sv
// Shared types for the nibble-word bus sequencers: the 2x4-bit packed word,
// the sequencer state encoding and the default park value.
package nib_bus_pkg;

   typedef bit [1:0][0:3] nib_word_t;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      GAP
   } nib_state_t;

   localparam nib_word_t NIB_PARK_DEFAULT = 8'h00;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester with req high,
// scanning upward from last+1 and wrapping, so the previous owner is checked last.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] sel,
   output logic             any
);

   logic found;

   // Scan NREQ positions starting after 'last'; the final step lands on 'last' itself.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[(int'(last) + k) % NREQ]) begin
            found = 1'b1;
            sel   = IDX_W'((int'(last) + k) % NREQ);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/nib_bus_rr_arbiter.sv
// Round-robin arbiter that grants one requester at a time and registers its
// word onto the shared nibble bus for a burst of len+1 cycles.
module nib_bus_rr_arbiter
   import nib_bus_pkg::*;
#(
   parameter int        NREQ     = 4,
   parameter nib_word_t PARK_VAL = NIB_PARK_DEFAULT,
   parameter int        IDX_W    = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0][1:0]  len,
   input  nib_word_t [NREQ-1:0]  wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [IDX_W-1:0]      owner,
   output nib_word_t             bus_q,
   output nib_word_t             bus_n,
   output logic                  bus_vld,
   output logic                  done,
   output logic                  abort
);

   nib_state_t       state;
   logic [1:0]       cnt;
   logic [IDX_W-1:0] pick_sel;
   logic             pick_any;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req  (req),
      .last (owner),
      .sel  (pick_sel),
      .any  (pick_any)
   );

   // Sequencer: IDLE picks an owner, BURST streams its words, GAP forces one dead
   // cycle before the next arbitration. done/abort are single-cycle pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt     <= '0;
         owner   <= IDX_W'(NREQ - 1);
         cnt     <= 2'd0;
         bus_q   <= PARK_VAL;
         bus_vld <= 1'b0;
         done    <= 1'b0;
         abort   <= 1'b0;
      end else begin
         done  <= 1'b0;
         abort <= 1'b0;
         case (state)
            IDLE: begin
               bus_q   <= PARK_VAL;
               bus_vld <= 1'b0;
               if (pick_any) begin
                  gnt   <= NREQ'(1) << pick_sel;
                  owner <= pick_sel;
                  cnt   <= len[pick_sel];
                  state <= BURST;
               end
            end
            BURST: begin
               if (!req[owner]) begin
                  bus_q   <= PARK_VAL;
                  bus_vld <= 1'b0;
                  done    <= 1'b1;
                  abort   <= 1'b1;
                  gnt     <= '0;
                  state   <= GAP;
               end else begin
                  bus_q   <= wdata[owner];
                  bus_vld <= 1'b1;
                  if (cnt == 2'd0) begin
                     done  <= 1'b1;
                     gnt   <= '0;
                     state <= GAP;
                  end else begin
                     cnt <= cnt - 2'd1;
                  end
               end
            end
            GAP: begin
               bus_q   <= PARK_VAL;
               bus_vld <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               bus_q   <= PARK_VAL;
               bus_vld <= 1'b0;
               gnt     <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // The complement is taken straight off the register so it can never diverge.
   assign bus_n = ~bus_q;

endmodule

// File: tb/tb_nib_bus_rr_arbiter.sv
// Self-checking bench for nib_bus_rr_arbiter: directed scenarios plus random
// traffic, all compared against a burst-level reference model.
module tb_nib_bus_rr_arbiter;
   import nib_bus_pkg::*;

   localparam int        NREQ = 4;
   localparam nib_word_t PARK = 8'h00;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0][1:0]  len;
   nib_word_t [NREQ-1:0]  wdata;
   logic [NREQ-1:0]       gnt;
   logic [1:0]            owner;
   nib_word_t             bus_q;
   nib_word_t             bus_n;
   logic                  bus_vld;
   logic                  done;
   logic                  abort;

   int tests  = 0;
   int failed = 0;

   // Reference model: who owns the bus, how many data beats remain, and whether
   // the mandatory dead cycle is pending.
   int              mOwner;
   bit              mBusy;
   bit              mGap;
   int              mBeats;
   logic [NREQ-1:0] eGnt;
   nib_word_t       eBus;
   bit              eVld, eDone, eAbort;

   nib_bus_rr_arbiter #(.NREQ(NREQ), .PARK_VAL(PARK)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .len     (len),
      .wdata   (wdata),
      .gnt     (gnt),
      .owner   (owner),
      .bus_q   (bus_q),
      .bus_n   (bus_n),
      .bus_vld (bus_vld),
      .done    (done),
      .abort   (abort)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [24:0] outVec();
      return {gnt, owner, bus_q, bus_n, bus_vld, done, abort};
   endfunction

   function automatic logic [24:0] expVec();
      nib_word_t inv;
      inv = ~eBus;
      return {eGnt, 2'(mOwner), eBus, inv, eVld, eDone, eAbort};
   endfunction

   task automatic modelReset();
      mOwner = NREQ - 1;
      mBusy  = 1'b0;
      mGap   = 1'b0;
      mBeats = 0;
      eGnt   = '0;
      eBus   = PARK;
      eVld   = 1'b0;
      eDone  = 1'b0;
      eAbort = 1'b0;
   endtask

   // Predict the outputs after the coming clock edge from the current inputs.
   task automatic modelStep();
      eDone  = 1'b0;
      eAbort = 1'b0;
      if (mGap) begin
         mGap = 1'b0;
         eVld = 1'b0;
         eBus = PARK;
      end else if (!mBusy) begin
         eVld = 1'b0;
         eBus = PARK;
         if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (req[(mOwner + k) % NREQ]) begin
                  mOwner = (mOwner + k) % NREQ;
                  break;
               end
            end
            eGnt   = '0;
            eGnt[mOwner] = 1'b1;
            mBeats = int'(len[mOwner]) + 1;
            mBusy  = 1'b1;
         end
      end else if (!req[mOwner]) begin
         eVld   = 1'b0;
         eBus   = PARK;
         eDone  = 1'b1;
         eAbort = 1'b1;
         eGnt   = '0;
         mBusy  = 1'b0;
         mGap   = 1'b1;
      end else begin
         eVld   = 1'b1;
         eBus   = wdata[mOwner];
         mBeats = mBeats - 1;
         if (mBeats == 0) begin
            eDone = 1'b1;
            eGnt  = '0;
            mBusy = 1'b0;
            mGap  = 1'b1;
         end
      end
   endtask

   task automatic advance();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic test_reset();
      req   = '0;
      len   = '0;
      wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (gnt !== 4'b0000) begin failed++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
      tests++;
      if (bus_q !== 8'h00) begin failed++; $display("[TB] FAIL reset_bus_q: got %h expected 00", bus_q); end
      tests++;
      if (bus_n !== 8'hFF) begin failed++; $display("[TB] FAIL reset_bus_n: got %h expected ff", bus_n); end
      tests++;
      if ({bus_vld, done, abort} !== 3'b000) begin failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus_vld, done, abort}); end
      tests++;
      if (owner !== 2'd3) begin failed++; $display("[TB] FAIL reset_owner: got %0d expected 3", owner); end
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic test_single();
      int vldCnt = 0;
      int doneCnt = 0;
      req      = 4'b0001;
      len[0]   = 2'd2;
      wdata[0] = 8'hA5;
      for (int i = 0; i < 7; i++) begin
         advance();
         tests++;
         if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL single_cyc%0d: got %h expected %h", i, outVec(), expVec()); end
         if (i == 0) begin
            tests++;
            if (gnt !== 4'b0001) begin failed++; $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); end
         end
         if (bus_vld) begin
            vldCnt++;
            tests++;
            if (bus_q !== 8'hA5 || bus_n !== 8'h5A) begin failed++; $display("[TB] FAIL single_data: got %h/%h expected a5/5a", bus_q, bus_n); end
         end
         if (done) begin
            doneCnt++;
            tests++;
            if (abort !== 1'b0) begin failed++; $display("[TB] FAIL single_abort: got %b expected 0", abort); end
            req = '0;
         end
      end
      tests++;
      if (vldCnt != 3) begin failed++; $display("[TB] FAIL single_beats: got %0d expected 3", vldCnt); end
      tests++;
      if (doneCnt != 1) begin failed++; $display("[TB] FAIL single_done: got %0d expected 1", doneCnt); end
   endtask

   task automatic test_round_robin();
      int grants[$];
      logic [NREQ-1:0] prevGnt = '0;
      applyReset();
      req = 4'b1111;
      len = '0;
      for (int i = 0; i < 15; i++) begin
         advance();
         tests++;
         if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL rr_cyc%0d: got %h expected %h", i, outVec(), expVec()); end
         if (gnt != '0 && prevGnt == '0) grants.push_back(int'(owner));
         prevGnt = gnt;
      end
      tests++;
      if (grants.size() != 5) begin
         failed++; $display("[TB] FAIL rr_count: got %0d grants expected 5", grants.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            tests++;
            if (grants[k] != k % NREQ) begin failed++; $display("[TB] FAIL rr_order%0d: got %0d expected %0d", k, grants[k], k % NREQ); end
         end
      end
      req = '0;
      repeat (3) begin
         advance();
         tests++;
         if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL rr_drain: got %h expected %h", outVec(), expVec()); end
      end
   endtask

   task automatic test_early_drop();
      int  dataSeen = 0;
      bit  dropped  = 1'b0;
      bit  checked  = 1'b0;
      req    = 4'b0100;
      len[2] = 2'd3;
      for (int i = 0; i < 12 && !checked; i++) begin
         wdata[2] = nib_word_t'($urandom_range(1, 255));
         advance();
         tests++;
         if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL drop_cyc%0d: got %h expected %h", i, outVec(), expVec()); end
         if (dropped) begin
            tests++;
            if ({bus_vld, done, abort} !== 3'b011 || bus_q !== 8'h00) begin
               failed++; $display("[TB] FAIL drop_end: got vld/done/abort=%b bus_q=%h expected 011/00", {bus_vld, done, abort}, bus_q);
            end
            advance();
            tests++;
            if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL drop_gap: got %h expected %h", outVec(), expVec()); end
            checked = 1'b1;
         end else begin
            if (bus_vld) dataSeen++;
            if (dataSeen == 2) begin
               req     = '0;
               dropped = 1'b1;
            end
         end
      end
      tests++;
      if (!checked) begin failed++; $display("[TB] FAIL drop_timeout: got no abort expected abort within 12 cycles"); end
      req = '0;
      advance();
   endtask

   task automatic test_mid_reset();
      int  vldCnt = 0;
      bit  hit    = 1'b0;
      req    = 4'b0010;
      len[1] = 2'd3;
      for (int i = 0; i < 10 && !hit; i++) begin
         wdata[1] = nib_word_t'($urandom);
         advance();
         tests++;
         if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL mreset_cyc%0d: got %h expected %h", i, outVec(), expVec()); end
         if (bus_vld) vldCnt++;
         if (vldCnt == 2) hit = 1'b1;
      end
      tests++;
      if (!hit) begin failed++; $display("[TB] FAIL mreset_timeout: got %0d data cycles expected 2", vldCnt); end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({gnt, owner, bus_q, bus_n, bus_vld, done, abort} !== {4'b0000, 2'd3, 8'h00, 8'hFF, 3'b000}) begin
         failed++; $display("[TB] FAIL mreset_values: got %h expected %h", outVec(), {4'b0000, 2'd3, 8'h00, 8'hFF, 3'b000});
      end
      @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b0) begin failed++; $display("[TB] FAIL mreset_nodone: got %b expected 0", done); end
      rst_n = 1'b1;
      modelReset();
      req = 4'b1111;
      len = '0;
      advance();
      tests++;
      if (gnt !== 4'b0001 || owner !== 2'd0) begin failed++; $display("[TB] FAIL mreset_regrant: got gnt=%b owner=%0d expected 0001/0", gnt, owner); end
      req = '0;
      repeat (3) begin
         advance();
         tests++;
         if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL mreset_drain: got %h expected %h", outVec(), expVec()); end
      end
   endtask

   task automatic test_late();
      int grants[$];
      logic [NREQ-1:0] prevGnt = '0;
      bit raised = 1'b0;
      req      = 4'b1000;
      len[3]   = 2'd3;
      len[1]   = 2'd0;
      wdata[1] = 8'h3C;
      wdata[3] = 8'hC3;
      for (int i = 0; i < 16; i++) begin
         advance();
         tests++;
         if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL late_cyc%0d: got %h expected %h", i, outVec(), expVec()); end
         if (gnt != '0 && prevGnt == '0) grants.push_back(int'(owner));
         prevGnt = gnt;
         if (grants.size() < 2 && bus_q === 8'h3C) begin
            failed++; $display("[TB] FAIL late_leak: got bus_q=3c expected no requester-1 data before its grant");
         end
         if (gnt == 4'b1000 && bus_vld && !raised) begin
            req[1] = 1'b1;
            raised = 1'b1;
         end
         if (done && owner == 2'd3) req[3] = 1'b0;
         if (done && owner == 2'd1) req[1] = 1'b0;
      end
      tests++;
      if (grants.size() < 2 || grants[0] != 3 || grants[1] != 1) begin
         failed++; $display("[TB] FAIL late_order: got %0d grants (first=%0d) expected 3 then 1", grants.size(), grants.size() > 0 ? grants[0] : -1);
      end
      req = '0;
      repeat (3) advance();
   endtask

   task automatic test_random();
      applyReset();
      req = '0;
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < NREQ; r++) begin
            if ($urandom_range(0, 5) == 0) req[r] = ~req[r];
            len[r]   = 2'($urandom);
            wdata[r] = nib_word_t'($urandom);
         end
         advance();
         tests++;
         if (outVec() !== expVec()) begin failed++; $display("[TB] FAIL random_cyc%0d: got %h expected %h", i, outVec(), expVec()); end
      end
   endtask

   initial begin
      req   = '0;
      len   = '0;
      wdata = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_early_drop();
      test_mid_reset();
      test_late();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
